// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: BCLK/LRCLK generator with frame-aligned dividers and clk_in-domain strobes.
// Divider and mode are re-sampled only at frame boundaries, so changes never shorten or stretch a BCLK phase.
module i2s_clock_gen #(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = 32,
  parameter int BIT_W     = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_half,
  input  logic             mode,
  output logic             bclk,
  output logic             lrclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             frame_start,
  output logic [BIT_W-1:0] bit_idx,
  output logic             channel,
  output logic             busy
);
  localparam int POS_W = BIT_W + 1;
  localparam logic [POS_W-1:0] P_SLOT = POS_W'(SLOT_BITS);
  localparam logic [POS_W-1:0] P_TOP  = POS_W'(SLOT_BITS - 1);
  localparam logic [POS_W-1:0] P_LAST = POS_W'(2 * SLOT_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state, w_state;
  logic [DIV_W-1:0]   r_div, w_div, r_cnt, w_cnt;
  logic [POS_W-1:0]   r_pos, w_pos, w_off, w_nxt;
  logic               r_mode, w_mode;
  logic               r_bclk, w_bclk, r_rise, w_rise, r_fall, w_fall, r_fs, w_fs;
  logic               r_lr, w_lr, r_chan, w_chan, r_busy, w_run;
  logic [BIT_W-1:0]   r_bit, w_bit;

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_mode  = r_mode;
    w_cnt   = r_cnt;
    w_pos   = r_pos;
    w_bclk  = r_bclk;
    w_rise  = 1'b0;
    w_fall  = 1'b0;
    w_fs    = 1'b0;
    if (r_state == IDLE) begin
      if (enable) begin
        w_state = RUN;
        w_div   = div_half;
        w_mode  = mode;
        w_cnt   = '0;
        w_pos   = '0;
        w_bclk  = 1'b0;
        w_fs    = 1'b1;
      end
    end else if (r_cnt != r_div) begin
      w_cnt = r_cnt + 1'b1;
    end else begin
      w_cnt  = '0;
      w_bclk = ~r_bclk;
      w_rise = ~r_bclk;
      w_fall = r_bclk;
      if (r_bclk) begin
        // Frame boundary: either re-arm with fresh settings or stop on this falling edge
        if (r_pos == P_LAST) begin
          w_pos = '0;
          if (enable) begin
            w_fs   = 1'b1;
            w_div  = div_half;
            w_mode = mode;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_pos = r_pos + 1'b1;
        end
      end
    end
    w_run  = (w_state == RUN);
    w_off  = (w_pos >= P_SLOT) ? w_pos - P_SLOT : w_pos;
    w_nxt  = (w_pos == P_LAST) ? '0 : w_pos + 1'b1;
    w_chan = w_run && (w_pos >= P_SLOT);
    w_bit  = w_run ? BIT_W'(P_TOP - w_off) : '0;
    w_lr   = w_run && (w_mode ? (w_pos >= P_SLOT) : (w_nxt >= P_SLOT));
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_bclk  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_fs    <= 1'b0;
      r_lr    <= 1'b0;
      r_chan  <= 1'b0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_mode  <= w_mode;
      r_cnt   <= w_cnt;
      r_pos   <= w_pos;
      r_bclk  <= w_run && w_bclk;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_fs    <= w_fs;
      r_lr    <= w_lr;
      r_chan  <= w_chan;
      r_bit   <= w_bit;
      r_busy  <= w_run;
    end
  end

  assign bclk        = r_bclk;
  assign lrclk       = r_lr;
  assign bclk_rise   = r_rise;
  assign bclk_fall   = r_fall;
  assign frame_start = r_fs;
  assign bit_idx     = r_bit;
  assign channel     = r_chan;
  assign busy        = r_busy;
endmodule

// File: tb/tb_i2s_clock_gen.sv
// tb_i2s_clock_gen: two instances (4-bit slots and default 32-bit slots) checked every cycle
// against a frame-time arithmetic model, plus literal checks of traces and frame lengths.
module tb_i2s_clock_gen;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic [1:0] en = '0;
  logic [1:0] md = '0;
  logic [7:0] dv [2];
  logic [1:0] o_bclk, o_lr, o_rise, o_fall, o_fs, o_ch, o_busy;
  logic [1:0] bit_a;
  logic [4:0] bit_b;
  int n_cmp = 0;
  int n_bad = 0;

  bit m_run [2];
  bit m_stop [2];
  bit m_first [2];
  bit m_m [2];
  int m_t [2];
  int m_d [2];

  always #5 clk_in = ~clk_in;

  i2s_clock_gen #(.SLOT_BITS(4), .BIT_W(2)) dut_a (
    .clk_in(clk_in), .reset(reset), .enable(en[0]), .div_half(dv[0]), .mode(md[0]),
    .bclk(o_bclk[0]), .lrclk(o_lr[0]), .bclk_rise(o_rise[0]), .bclk_fall(o_fall[0]),
    .frame_start(o_fs[0]), .bit_idx(bit_a), .channel(o_ch[0]), .busy(o_busy[0]));

  i2s_clock_gen dut_b (
    .clk_in(clk_in), .reset(reset), .enable(en[1]), .div_half(dv[1]), .mode(md[1]),
    .bclk(o_bclk[1]), .lrclk(o_lr[1]), .bclk_rise(o_rise[1]), .bclk_fall(o_fall[1]),
    .frame_start(o_fs[1]), .bit_idx(bit_b), .channel(o_ch[1]), .busy(o_busy[1]));

  // Model state: time t within the current frame, plus the settings latched for that frame
  always @(posedge clk_in or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_run[i]  <= 1'b0;
        m_stop[i] <= 1'b0;
      end else if (!m_run[i]) begin
        m_stop[i] <= 1'b0;
        if (en[i]) begin
          m_run[i] <= 1'b1; m_t[i] <= 0; m_d[i] <= int'(dv[i]); m_m[i] <= md[i]; m_first[i] <= 1'b1;
        end
      end else if (m_t[i] == 4 * (i ? 32 : 4) * (m_d[i] + 1) - 1) begin
        if (en[i]) begin
          m_t[i] <= 0; m_d[i] <= int'(dv[i]); m_m[i] <= md[i]; m_first[i] <= 1'b0;
        end else begin
          m_run[i] <= 1'b0; m_stop[i] <= 1'b1;
        end
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  // {busy, bclk, lrclk, rise, fall, frame_start, channel, bit_idx[7:0]}
  function automatic logic [14:0] expv(int s, bit run, bit stop, bit first, int t, int d, bit m);
    logic [14:0] r;
    int h, p, ph;
    r = '0;
    if (stop) begin
      r[10] = 1'b1;
    end else if (run) begin
      h = d + 1;
      p = t / (2 * h);
      ph = t % (2 * h);
      r[14] = 1'b1;
      r[13] = (ph >= h);
      r[12] = m ? (p >= s) : (((p + 1) % (2 * s)) >= s);
      r[11] = (ph == h);
      r[10] = (ph == 0) && !(t == 0 && first);
      r[9]  = (t == 0);
      r[8]  = (p >= s);
      r[7:0] = 8'(s - 1 - p % s);
    end
    return r;
  endfunction

  function automatic logic [14:0] actv(int i);
    return {o_busy[i], o_bclk[i], o_lr[i], o_rise[i], o_fall[i], o_fs[i], o_ch[i],
            (i == 1) ? {3'b0, bit_b} : {6'b0, bit_a}};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk_in)
    for (int i = 0; i < 2; i++)
      check(i ? "outs_b" : "outs_a", 32'(actv(i)),
            32'(expv(i ? 32 : 4, m_run[i], m_stop[i], m_first[i], m_t[i], m_d[i], m_m[i])));

  task automatic wait_fs(input int i, input int budget, output int c);
    c = 0;
    do begin
      @(negedge clk_in);
      c++;
    end while (!o_fs[i] && c < budget);
    if (!o_fs[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_fs inst %0d: no frame_start within %0d cycles", i, budget);
    end
  endtask

  initial begin
    int c, nr, lr_r, lr_f, r1, r2, bat;
    logic [15:0] lt;
    logic [31:0] bt;
    logic pl;
    dv[0] = 8'd0;
    dv[1] = 8'd0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    // Left-justified, div_half=0: 2-cycle BCLK, 16-cycle frame
    @(negedge clk_in);
    dv[0] = 8'd0; md[0] = 1'b1; en[0] = 1'b1;
    wait_fs(0, 100, c);
    wait_fs(0, 100, c);
    check("fs_period_a", c, 16);
    lt = '0; bt = '0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk_in);
      lt = {lt[14:0], o_lr[0]};
      bt = {bt[29:0], bit_a};
    end
    check("lr_trace", 32'(lt), 32'h0000_00FF);
    check("bit_trace", bt, 32'hFA50_FA50);
    // I2S, div_half=1, taken at the coming boundary
    md[0] = 1'b0; dv[0] = 8'd1;
    wait_fs(0, 100, c);
    lr_r = -1; lr_f = -1; r1 = -1; r2 = -1; bat = -1; pl = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k != 0) @(negedge clk_in);
      if (o_lr[0] && !pl && lr_r < 0) begin lr_r = k; bat = int'(bit_a); end
      if (!o_lr[0] && pl && lr_f < 0) lr_f = k;
      pl = o_lr[0];
      if (o_rise[0]) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
    end
    check("i2s_lr_rise", lr_r, 12);
    check("i2s_lr_fall", lr_f, 28);
    check("i2s_bit_at_rise", bat, 0);
    check("i2s_bclk_period", r2 - r1, 4);
    // Divider change at pos=2 only takes effect at the next boundary
    wait_fs(0, 100, c);
    repeat (8) @(negedge clk_in);
    dv[0] = 8'd3;
    wait_fs(0, 100, c);
    check("frame_old_div", c, 24);
    wait_fs(0, 200, c);
    check("frame_new_div", c, 64);
    // Stop requested at pos=5: frame completes, then idle
    repeat (40) @(negedge clk_in);
    en[0] = 1'b0;
    c = 0;
    do begin
      @(negedge clk_in);
      c++;
    end while (!(o_fall[0] && !o_busy[0]) && c < 100);
    check("stop_at", c, 24);
    check("stop_outs", {o_fall[0], o_fs[0], o_busy[0], o_lr[0], o_bclk[0]}, 5'b10000);
    repeat (20) @(negedge clk_in);
    check("idle_after_stop", o_busy[0], 0);
    // Asynchronous reset in the middle of a run
    dv[0] = 8'd0; md[0] = 1'b1; en[0] = 1'b1;
    repeat (11) @(negedge clk_in);
    @(posedge clk_in);
    #2 reset = 1'b0;
    #1 check("async_reset", {actv(0), actv(1)}, 0);
    en[0] = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    repeat (100) @(negedge clk_in);
    check("idle_100", {actv(0), actv(1)}, 0);
    // Default instance, div_half=7: 1024-cycle frame with 64 BCLK rises
    dv[1] = 8'd7; en[1] = 1'b1;
    wait_fs(1, 10, c);
    c = 0; nr = 0;
    do begin
      @(negedge clk_in);
      c++;
      if (o_rise[1]) nr++;
    end while (!o_fs[1] && c < 2000);
    check("frame_len_b", c, 1024);
    check("rises_b", nr, 64);
    en[1] = 1'b0;
    c = 0;
    do begin
      @(negedge clk_in);
      c++;
    end while (o_busy[1] && c < 1100);
    check("stopped_b", o_busy[1], 0);
    repeat (2) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
